// File: rtl/tx_buffer_pkg.sv
// Shared widths, state encoding and helpers for the AES-to-UART return path.
// The CSUM state only exists when TX_CHECKSUM_EN is defined.
package tx_buffer_pkg;

    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned BYTES_PER_BLOCK = 16;
    localparam int unsigned BYTE_CNT_W      = $clog2(BYTES_PER_BLOCK);
    localparam int unsigned STATE_W         = 3;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [BYTE_W-1:0]  byte_t;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3
`ifdef TX_CHECKSUM_EN
        ,
        CSUM  = 3'd4
`endif
    } tx_state_e;

    // Most-significant byte of a block; that byte goes out on the wire first.
    function automatic byte_t top_byte(input block_t blk);
        return blk[BLOCK_W-1 -: BYTE_W];
    endfunction

endpackage

// File: rtl/block_fifo.sv
// Block FIFO holding DEPTH result blocks between the AES core and the serializer.
// Pushes into a full FIFO are dropped and latch a sticky overflow flag.
module block_fifo
    import tx_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  block_t wr_data,
    input  logic   push,
    input  logic   pop,
    output block_t head_c,
    output logic   full,
    output logic   empty,
    output logic   overflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    block_t            mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    // Occupancy update; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: ;
        endcase
    end

    // Pointers, count and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
            if (push && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Block storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/tx_shift.sv
// Serializer: pops a block, shifts it out MSB byte first with a tx_start/tx_done
// handshake per byte. With TX_CHECKSUM_EN defined, a 17th byte carrying the XOR
// of the 16 data bytes follows each block.
module tx_shift
    import tx_buffer_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  block_t head_c,
    input  logic   empty,
    input  logic   tx_done,
    output logic   pop_c,
    output byte_t  tx_byte,
    output logic   tx_start,
    output logic   busy
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_BLOCK - 1);

    tx_state_e               state;
    tx_state_e               state_next;
    block_t                  shreg;
    block_t                  shreg_next;
    logic [BYTE_CNT_W-1:0]   byte_cnt;
    logic [BYTE_CNT_W-1:0]   byte_cnt_next;
    byte_t                   tx_byte_next;
    logic                    tx_start_next;
    logic                    busy_next;
`ifdef TX_CHECKSUM_EN
    byte_t                   csum;
    byte_t                   csum_next;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; tx_done only matters while a byte is in flight.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = LOAD;
                end
            end
            LOAD:  state_next = START;
            START: state_next = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (byte_cnt == LAST_BYTE) begin
`ifdef TX_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = IDLE;
`endif
                    end else begin
                        state_next = START;
                    end
                end
            end
`ifdef TX_CHECKSUM_EN
            // The entry cycle carries the tx_start pulse, so a done can only follow it.
            CSUM: begin
                if (tx_done && !tx_start) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output next values; the byte register loads on entry to START.
    always_comb begin
        pop_c         = 1'b0;
        shreg_next    = shreg;
        byte_cnt_next = byte_cnt;
        tx_byte_next  = tx_byte;
        tx_start_next = 1'b0;
        busy_next     = (state_next != IDLE);
`ifdef TX_CHECKSUM_EN
        csum_next     = csum;
`endif
        unique case (state)
            LOAD: begin
                pop_c         = 1'b1;
                shreg_next    = head_c;
                byte_cnt_next = '0;
            end
            WAIT: begin
                if (tx_done && (byte_cnt != LAST_BYTE)) begin
                    shreg_next    = shreg << BYTE_W;
                    byte_cnt_next = byte_cnt + BYTE_CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (state_next == START) begin
            tx_byte_next  = top_byte(shreg_next);
            tx_start_next = 1'b1;
`ifdef TX_CHECKSUM_EN
            csum_next     = ((state == LOAD) ? byte_t'(0) : csum) ^ top_byte(shreg_next);
`endif
        end

`ifdef TX_CHECKSUM_EN
        if ((state_next == CSUM) && (state != CSUM)) begin
            tx_byte_next  = csum;
            tx_start_next = 1'b1;
        end
`endif
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            byte_cnt <= '0;
            tx_byte  <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
`ifdef TX_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            shreg    <= shreg_next;
            byte_cnt <= byte_cnt_next;
            tx_byte  <= tx_byte_next;
            tx_start <= tx_start_next;
            busy     <= busy_next;
`ifdef TX_CHECKSUM_EN
            csum     <= csum_next;
`endif
        end
    end

endmodule

// File: rtl/transmitter_buffer.sv
// Return path from the AES core to the UART transmitter: block FIFO feeding a
// byte serializer. Optional per-block XOR checksum byte under TX_CHECKSUM_EN.
module transmitter_buffer
    import tx_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] block_aes_to_buffer,
    input  logic               write_en,
    input  logic               tx_done,
    output logic [BYTE_W-1:0]  byte_shiftReg_to_UART_tx,
    output logic               tx_start,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic               busy
);

    block_t head_c;
    logic   pop_c;

    block_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (block_aes_to_buffer),
        .push     (write_en),
        .pop      (pop_c),
        .head_c   (head_c),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    tx_shift u_shift (
        .clk      (clk),
        .reset    (reset),
        .head_c   (head_c),
        .empty    (empty),
        .tx_done  (tx_done),
        .pop_c    (pop_c),
        .tx_byte  (byte_shiftReg_to_UART_tx),
        .tx_start (tx_start),
        .busy     (busy)
    );

endmodule
